// File: rtl/wqe_cache_pkg.sv
// Shared constants for the per-QP WQE cache: WQE field positions and drop counter width.
package wqe_cache_pkg;

    localparam int WRID_LSB   = 0;
    localparam int WRID_MSB   = 63;
    localparam int QPID_LSB   = 328;
    localparam int DROP_CNT_W = 16;

    function automatic int qpid_msb(input int qp_ptr_width);
        return QPID_LSB + qp_ptr_width - 1;
    endfunction

endpackage

// File: rtl/wqe_rr_arbiter.sv
// Round-robin arbiter over the per-QP queues; owns the rr pointer, which advances past
// the granted queue on each accepted grant.
module wqe_rr_arbiter #(
    parameter int PTR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**PTR_W-1:0]   i_req,
    input  logic                  i_accept,
    output logic [2**PTR_W-1:0]   o_gnt_oh,
    output logic [PTR_W-1:0]      o_gnt_idx,
    output logic                  o_gnt_val
);

    localparam int N = 2**PTR_W;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] idx;

    // Scan starting at rr_ptr; the index wraps naturally at PTR_W bits.
    always_comb begin
        o_gnt_val = 1'b0;
        o_gnt_idx = '0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            idx = rr_ptr_q + PTR_W'(i);
            if (!o_gnt_val && i_req[idx]) begin
                o_gnt_val = 1'b1;
                o_gnt_idx = idx;
            end
        end
    end

    always_comb begin
        o_gnt_oh = o_gnt_val ? (N'(1) << o_gnt_idx) : '0;
        rr_ptr_d = rr_ptr_q;
        if (i_accept && o_gnt_val) begin
            rr_ptr_d = o_gnt_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/wqe_multi_qp_cache.sv
// Per-QP WQE cache: circular queues in one shared array, drained round-robin into a
// registered output stage. Define WQE_CACHE_DROP_CNT_EN to add the o_drop_cnt port.
module wqe_multi_qp_cache
    import wqe_cache_pkg::*;
#(
    parameter int WQE_WIDTH     = 512,
    parameter int QP_PTR_WIDTH  = 4,
    parameter int DEPTH_LOG2    = 3,
    parameter int ALFULL_MARGIN = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wqe_cache_wr,
    input  logic [WQE_WIDTH-1:0]      i_wqe,
    output logic [2**QP_PTR_WIDTH-1:0] o_wqe_cache_alfull,
    output logic [2**QP_PTR_WIDTH-1:0] o_wqe_cache_full,
    output logic                      o_wqe_cache_empty,
    input  logic                      i_qp_flush_val,
    input  logic [QP_PTR_WIDTH-1:0]   i_qp_flush_qpn,
    output logic                      o_wqe_val,
    input  logic                      i_wqe_rdy,
    output logic [WQE_WIDTH-1:0]      o_wqe,
    output logic [QP_PTR_WIDTH-1:0]   o_wqe_qpn,
    output logic                      o_wqe_cache_wr_val,
    output logic [QP_PTR_WIDTH-1:0]   o_wqe_cache_wr_qpn,
    output logic [63:0]               o_wqe_cache_wr_wrid
`ifdef WQE_CACHE_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]     o_drop_cnt
`endif
);

    localparam int N_QP     = 2**QP_PTR_WIDTH;
    localparam int DEPTH    = 2**DEPTH_LOG2;
    localparam int CNT_W    = DEPTH_LOG2 + 1;
    localparam int ADDR_W   = QP_PTR_WIDTH + DEPTH_LOG2;
    localparam int QPID_MSB = qpid_msb(QP_PTR_WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ALFULL = CNT_W'(DEPTH - ALFULL_MARGIN);

    logic [DEPTH_LOG2-1:0] wr_ptr_q [N_QP];
    logic [DEPTH_LOG2-1:0] wr_ptr_d [N_QP];
    logic [DEPTH_LOG2-1:0] rd_ptr_q [N_QP];
    logic [DEPTH_LOG2-1:0] rd_ptr_d [N_QP];
    logic [CNT_W-1:0]      cnt_q    [N_QP];
    logic [CNT_W-1:0]      cnt_d    [N_QP];
    logic [WQE_WIDTH-1:0]  mem      [2**ADDR_W];

    logic                    out_val_q, out_val_d;
    logic [WQE_WIDTH-1:0]    out_wqe_q, out_wqe_d;
    logic [QP_PTR_WIDTH-1:0] out_qpn_q, out_qpn_d;

    logic [QP_PTR_WIDTH-1:0] wr_qpn;
    logic [N_QP-1:0]         flush_oh, nonempty, req, push, pop;
    logic [N_QP-1:0]         gnt_oh;
    logic [QP_PTR_WIDTH-1:0] gnt_idx;
    logic                    gnt_val;
    logic                    wr_acc, load;
    logic [ADDR_W-1:0]       wr_addr, rd_addr;

    assign wr_qpn   = i_wqe[QPID_MSB:QPID_LSB];
    assign flush_oh = i_qp_flush_val ? (N_QP'(1) << i_qp_flush_qpn) : '0;

    always_comb begin
        for (int q = 0; q < N_QP; q++) begin
            o_wqe_cache_full[q]   = (cnt_q[q] == CNT_FULL);
            o_wqe_cache_alfull[q] = (cnt_q[q] >= CNT_ALFULL);
            nonempty[q]           = (cnt_q[q] != '0);
        end
    end

    // Full uses the registered count, so a same-cycle pop never rescues a write.
    assign wr_acc  = i_wqe_cache_wr & ~o_wqe_cache_full[wr_qpn] & ~flush_oh[wr_qpn];
    assign req     = nonempty & ~flush_oh;
    assign load    = gnt_val & (~out_val_q | i_wqe_rdy);
    assign push    = wr_acc ? (N_QP'(1) << wr_qpn) : '0;
    assign pop     = load ? gnt_oh : '0;
    assign wr_addr = {wr_qpn, wr_ptr_q[wr_qpn]};
    assign rd_addr = {gnt_idx, rd_ptr_q[gnt_idx]};

    wqe_rr_arbiter #(
        .PTR_W (QP_PTR_WIDTH)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (req),
        .i_accept  (load),
        .o_gnt_oh  (gnt_oh),
        .o_gnt_idx (gnt_idx),
        .o_gnt_val (gnt_val)
    );

    always_comb begin
        for (int q = 0; q < N_QP; q++) begin
            wr_ptr_d[q] = wr_ptr_q[q];
            rd_ptr_d[q] = rd_ptr_q[q];
            cnt_d[q]    = cnt_q[q];
            if (flush_oh[q]) begin
                wr_ptr_d[q] = '0;
                rd_ptr_d[q] = '0;
                cnt_d[q]    = '0;
            end else begin
                if (push[q]) wr_ptr_d[q] = wr_ptr_q[q] + DEPTH_LOG2'(1);
                if (pop[q])  rd_ptr_d[q] = rd_ptr_q[q] + DEPTH_LOG2'(1);
                if (push[q] && !pop[q]) begin
                    cnt_d[q] = cnt_q[q] + CNT_W'(1);
                end else if (!push[q] && pop[q]) begin
                    cnt_d[q] = cnt_q[q] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        out_val_d = out_val_q;
        out_wqe_d = out_wqe_q;
        out_qpn_d = out_qpn_q;
        if (load) begin
            out_val_d = 1'b1;
            out_wqe_d = mem[rd_addr];
            out_qpn_d = gnt_idx;
        end else if (i_wqe_rdy) begin
            out_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int q = 0; q < N_QP; q++) begin
                wr_ptr_q[q] <= '0;
                rd_ptr_q[q] <= '0;
                cnt_q[q]    <= '0;
            end
            out_val_q <= 1'b0;
            out_wqe_q <= '0;
            out_qpn_q <= '0;
        end else begin
            for (int q = 0; q < N_QP; q++) begin
                wr_ptr_q[q] <= wr_ptr_d[q];
                rd_ptr_q[q] <= rd_ptr_d[q];
                cnt_q[q]    <= cnt_d[q];
            end
            out_val_q <= out_val_d;
            out_wqe_q <= out_wqe_d;
            out_qpn_q <= out_qpn_d;
        end
    end

    // Storage has no reset; pointers and counts define which slots are live.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_addr] <= i_wqe;
        end
    end

    assign o_wqe_val           = out_val_q;
    assign o_wqe               = out_wqe_q;
    assign o_wqe_qpn           = out_qpn_q;
    assign o_wqe_cache_empty   = ~|nonempty & ~out_val_q;
    assign o_wqe_cache_wr_val  = wr_acc;
    assign o_wqe_cache_wr_qpn  = wr_qpn;
    assign o_wqe_cache_wr_wrid = i_wqe[WRID_MSB:WRID_LSB];

`ifdef WQE_CACHE_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_wqe_cache_wr && !wr_acc && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_wqe_multi_qp_cache.sv
// Scoreboard bench for wqe_multi_qp_cache: accepted WQEs are queued in expected output
// order and compared as the consumer takes them.
module tb_wqe_multi_qp_cache;

    localparam int W  = 512;
    localparam int PW = 4;
    localparam int NQ = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_wqe_cache_wr;
    logic [W-1:0]  i_wqe;
    logic [NQ-1:0] o_wqe_cache_alfull;
    logic [NQ-1:0] o_wqe_cache_full;
    logic          o_wqe_cache_empty;
    logic          i_qp_flush_val;
    logic [PW-1:0] i_qp_flush_qpn;
    logic          o_wqe_val;
    logic          i_wqe_rdy;
    logic [W-1:0]  o_wqe;
    logic [PW-1:0] o_wqe_qpn;
    logic          o_wqe_cache_wr_val;
    logic [PW-1:0] o_wqe_cache_wr_qpn;
    logic [63:0]   o_wqe_cache_wr_wrid;
`ifdef WQE_CACHE_DROP_CNT_EN
    logic [15:0]   o_drop_cnt;
`endif

    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] sb [$];
    logic [W-1:0] mon_exp;

    always #5 clk = ~clk;

    wqe_multi_qp_cache dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_wqe_cache_wr      (i_wqe_cache_wr),
        .i_wqe               (i_wqe),
        .o_wqe_cache_alfull  (o_wqe_cache_alfull),
        .o_wqe_cache_full    (o_wqe_cache_full),
        .o_wqe_cache_empty   (o_wqe_cache_empty),
        .i_qp_flush_val      (i_qp_flush_val),
        .i_qp_flush_qpn      (i_qp_flush_qpn),
        .o_wqe_val           (o_wqe_val),
        .i_wqe_rdy           (i_wqe_rdy),
        .o_wqe               (o_wqe),
        .o_wqe_qpn           (o_wqe_qpn),
        .o_wqe_cache_wr_val  (o_wqe_cache_wr_val),
        .o_wqe_cache_wr_qpn  (o_wqe_cache_wr_qpn),
        .o_wqe_cache_wr_wrid (o_wqe_cache_wr_wrid)
`ifdef WQE_CACHE_DROP_CNT_EN
        ,
        .o_drop_cnt          (o_drop_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] make_wqe(input logic [PW-1:0] qpn, input logic [63:0] wrid);
        logic [W-1:0] w;
        for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
        w[63:0]     = wrid;
        w[328 +: PW] = qpn;
        return w;
    endfunction

    // Drives one write for a cycle; keep=1 means the WQE is expected at the output.
    task automatic write_wqe(input logic [PW-1:0] qpn, input logic [63:0] wrid,
                             input logic exp_acc, input logic keep);
        logic [W-1:0] w;
        w = make_wqe(qpn, wrid);
        i_wqe          = w;
        i_wqe_cache_wr = 1'b1;
        if (keep) sb.push_back(w);
        #1;
        check_eq("wr_val", W'(o_wqe_cache_wr_val), W'(exp_acc));
        check_eq("wr_qpn", W'(o_wqe_cache_wr_qpn), W'(qpn));
        check_eq("wr_wrid", W'(o_wqe_cache_wr_wrid), W'(wrid));
        @(posedge clk);
        #1;
        i_wqe_cache_wr = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        i_wqe_rdy = 1'b1;
        for (int i = 0; i < max_cyc && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_left", W'(sb.size()), W'(0));
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        i_wqe_cache_wr = 1'b0;
        i_qp_flush_val = 1'b0;
        i_wqe_rdy      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic check_drop(input string tag, input int exp);
`ifdef WQE_CACHE_DROP_CNT_EN
        check_eq(tag, W'(o_drop_cnt), W'(exp));
`else
        if (exp < 0) $display("unused drop tag %s", tag);
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && o_wqe_val && i_wqe_rdy) begin
            if (sb.size() == 0) begin
                check_eq("sb_extra", W'(sb.size()), W'(1));
            end else begin
                mon_exp = sb.pop_front();
                check_eq("out_wqe", o_wqe, mon_exp);
                check_eq("out_qpn", W'(o_wqe_qpn), W'(mon_exp[328 +: PW]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        i_wqe          = '0;
        i_qp_flush_qpn = '0;
        do_reset();
        check_eq("rst_val", W'(o_wqe_val), W'(0));
        check_eq("rst_wqe", o_wqe, W'(0));
        check_eq("rst_qpn", W'(o_wqe_qpn), W'(0));
        check_eq("rst_full", W'(o_wqe_cache_full), W'(0));
        check_eq("rst_alfull", W'(o_wqe_cache_alfull), W'(0));
        check_eq("rst_empty", W'(o_wqe_cache_empty), W'(1));
        check_drop("rst_drop", 0);

        // Three WQEs to QP2 streaming out back to back.
        i_wqe_rdy = 1'b1;
        write_wqe(4'd2, 64'h201, 1'b1, 1'b1);
        check_eq("t1_pre", W'(o_wqe_val), W'(0));
        write_wqe(4'd2, 64'h202, 1'b1, 1'b1);
        check_eq("t1_lat", W'(o_wqe_val), W'(1));
        check_eq("t1_id1", W'(o_wqe[63:0]), W'(64'h201));
        write_wqe(4'd2, 64'h203, 1'b1, 1'b1);
        check_eq("t1_v2", W'(o_wqe_val), W'(1));
        check_eq("t1_id2", W'(o_wqe[63:0]), W'(64'h202));
        @(posedge clk);
        #1;
        check_eq("t1_v3", W'(o_wqe_val), W'(1));
        check_eq("t1_id3", W'(o_wqe[63:0]), W'(64'h203));
        @(posedge clk);
        #1;
        check_eq("t1_idle", W'(o_wqe_val), W'(0));
        check_eq("t1_sb", W'(sb.size()), W'(0));

        // Interleaved QPs 0/5/15: round robin must wrap 15 -> 0.
        do_reset();
        write_wqe(4'd0, 64'h1, 1'b1, 1'b1);
        write_wqe(4'd5, 64'h2, 1'b1, 1'b1);
        write_wqe(4'd15, 64'h3, 1'b1, 1'b1);
        write_wqe(4'd0, 64'h4, 1'b1, 1'b1);
        write_wqe(4'd5, 64'h5, 1'b1, 1'b1);
        write_wqe(4'd15, 64'h6, 1'b1, 1'b1);
        check_eq("t2_hold_qpn", W'(o_wqe_qpn), W'(0));
        check_eq("t2_hold_id", W'(o_wqe[63:0]), W'(64'h1));
        drain(20);
        check_drop("t2_drop", 0);

        // Fill QP7 behind an occupied output stage; the 9th write is dropped.
        do_reset();
        write_wqe(4'd0, 64'h300, 1'b1, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            write_wqe(4'd7, 64'h700 + 64'(i), 1'b1, 1'b1);
            check_eq($sformatf("t3_alfull%0d", i), W'(o_wqe_cache_alfull[7]), W'(i >= 7));
            check_eq($sformatf("t3_full%0d", i), W'(o_wqe_cache_full[7]), W'(i == 8));
        end
        write_wqe(4'd7, 64'h709, 1'b0, 1'b0);
        check_eq("t3_full_hold", W'(o_wqe_cache_full[7]), W'(1));
        check_drop("t3_drop", 1);
        drain(20);
        check_eq("t3_full_clr", W'(o_wqe_cache_full), W'(0));

        // Full QP1: a push in the same cycle as a pop is still rejected.
        do_reset();
        write_wqe(4'd0, 64'h400, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) write_wqe(4'd1, 64'h410 + 64'(i), 1'b1, 1'b1);
        check_eq("t4_full", W'(o_wqe_cache_full[1]), W'(1));
        i_wqe_rdy = 1'b1;
        write_wqe(4'd1, 64'h4ff, 1'b0, 1'b0);
        i_wqe_rdy = 1'b0;
        check_eq("t4_full7", W'(o_wqe_cache_full[1]), W'(0));
        check_eq("t4_alfull7", W'(o_wqe_cache_alfull[1]), W'(1));
        check_eq("t4_stage_qpn", W'(o_wqe_qpn), W'(1));
        check_drop("t4_drop", 1);
        drain(20);

        // Flush QP3 while writing to it; the next write must be the only QP3 output.
        do_reset();
        write_wqe(4'd0, 64'h500, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) write_wqe(4'd3, 64'h530 + 64'(i), 1'b1, 1'b0);
        i_qp_flush_val = 1'b1;
        i_qp_flush_qpn = 4'd3;
        write_wqe(4'd3, 64'h53f, 1'b0, 1'b0);
        i_qp_flush_val = 1'b0;
        check_eq("t5_empty_busy", W'(o_wqe_cache_empty), W'(0));
        check_drop("t5_drop", 1);
        write_wqe(4'd3, 64'h540, 1'b1, 1'b1);
        drain(20);
        check_eq("t5_empty", W'(o_wqe_cache_empty), W'(1));

        // Reset with a valid output stage.
        do_reset();
        for (int i = 0; i < 3; i++) write_wqe(4'd4, 64'h600 + 64'(i), 1'b1, 1'b0);
        check_eq("t6_val_pre", W'(o_wqe_val), W'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t6_val", W'(o_wqe_val), W'(0));
        check_eq("t6_full", W'(o_wqe_cache_full), W'(0));
        check_eq("t6_alfull", W'(o_wqe_cache_alfull), W'(0));
        check_eq("t6_empty", W'(o_wqe_cache_empty), W'(1));
        rst = 1'b0;
        sb.delete();
        write_wqe(4'd4, 64'h6aa, 1'b1, 1'b1);
        drain(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
